if_id_buffer: RTL

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer.sv | 77 +++++++
 1 files changed

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a 2-entry FIFO that decouples instruction fetch from
// decode, with a synchronous flush for taken branches and a decode-starvation counter.
module if_id_buffer #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_instr,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_instr,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         flush,
  output logic [1:0]   count,
  output logic [7:0]   bubble_cnt
);

  if (DEPTH != 2) begin : g_depth_check
    $error("if_id_buffer supports DEPTH == 2 only");
  end

  // Handshake: a word moves on a rising edge only when its valid and ready
  // are both 1 there. in_ready comes from registered count alone, so there
  // is no combinational path from out_ready back to the fetch side.
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_instr = mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      // Flush wins over any same-cycle push or pop; stored data is left as-is.
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_instr;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Starvation counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= 8'd0;
    end else if (out_ready && !out_valid && (bubble_cnt != 8'hFF)) begin
      bubble_cnt <= bubble_cnt + 8'd1;
    end
  end

endmodule
